matmul_apb_slave: RTL and testbench
===================================

Name: matmul_apb_slave

Overview:
- APB3 slave front-end of the matmul accelerator, sitting directly upstream of the matmul core.
- Holds the CONTROL register, operand A/B rows, a sticky FLAGS register and SP_NTARGETS result scratchpad slots.
- Issues the start pulse to the core and captures the core's result matrix and overflow flags.
- All storage is exposed to the core as flattened buses.

Parameters:
- BUS_WIDTH, 64: APB data width; also the result element width.
- DATA_WIDTH, 32: operand element width.
- ADDR_WIDTH, 16: APB address width.
- SP_NTARGETS, 4: number of scratchpad result slots (power of 2, ≤4).
- MAX_DIM, BUS_WIDTH/DATA_WIDTH: maximum matrix dimension N (≤4).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1=write, 0=read.
- paddr_i  in  ADDR_WIDTH  byte address.
- pwdata_i  in  BUS_WIDTH  write data.
- prdata_o  out  BUS_WIDTH  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error; valid only with pready_o.
- busy_i  in  1  core computing.
- res_valid_i  in  1  one-cycle pulse: result matrix valid.
- res_data_i  in  MAX_DIM*MAX_DIM*BUS_WIDTH  result elements, row-major, element 0 in LSBs.
- flags_i  in  MAX_DIM*MAX_DIM  per-element overflow, sampled with res_valid_i.
- start_o  out  1  one-cycle start pulse.
- ctrl_o  out  16  CONTROL[15:0].
- a_o  out  MAX_DIM*BUS_WIDTH  operand A rows.
- b_o  out  MAX_DIM*BUS_WIDTH  operand B rows.
- c_o  out  MAX_DIM*MAX_DIM*BUS_WIDTH  scratchpad slot CONTROL.read_target (bias matrix).

Behaviour:
- Word index W = paddr_i[ADDR_WIDTH-1:3]. Any paddr_i[2:0] ≠ 0 gives pslverr_o=1 and the access is ignored.
- Address map, with N=MAX_DIM:
  - W=0: CONTROL.
  - W=1..N: A rows.
  - W=N+1..2N: B rows.
  - W=2N+1: FLAGS.
  - W=2N+2 .. 2N+1+SP_NTARGETS*N*N: scratchpad, slot-major then row-major.
  - Any other W: pslverr_o=1, read data 0.
- CONTROL fields:
  - [0] start: write 1 → start_o=1 the next cycle; the bit is never stored and reads 0.
  - [1] mode_bias.
  - [3:2] write_target.
  - [5:4] read_target.
  - [9:8] N-1, [11:10] K-1, [13:12] M-1.
  - [15:14] reserved, read 0.
  - Bits ≥16 are ignored on write and read 0.
- FSM IDLE → SETUP → ACCESS → IDLE:
  - SETUP is entered on psel_i & !penable_i.
  - The ACCESS first cycle (penable_i=1) is a wait state: pready_o=0, read data is registered.
  - The ACCESS second cycle drives pready_o=1, plus prdata_o/pslverr_o. Write side effects commit on this cycle.
  - Back-to-back transfers: from IDLE the FSM samples the next setup on the cycle after pready_o.
  - psel_i dropping mid-transfer returns the FSM to IDLE with no side effect.
- Busy rule: while busy_i=1, APB writes to CONTROL, A, B or scratchpad return pslverr_o=1 and are ignored. Reads and FLAGS writes are always allowed.
- Start: start_o is a single-cycle pulse, never asserted while busy_i=1 (the write errors instead).
- Result capture: on res_valid_i, all N*N elements are written to slot CONTROL.write_target in one cycle.
- FLAGS: on res_valid_i, FLAGS[MAX_DIM*MAX_DIM-1:0] |= flags_i (sticky).
  - An APB write to FLAGS clears it to 0.
  - If that clear coincides with res_valid_i, the new flags_i win (FLAGS=flags_i).
- Scratchpad collision: the busy rule prevents an APB scratchpad write coinciding with res_valid_i; if it still occurs, the core write wins.
- Read-during-capture: an APB read samples storage in the wait-state cycle, i.e. the pre-capture value.
- Reset values (rst_ni=0, asynchronous): FSM=IDLE; pready_o=0; pslverr_o=0; prdata_o=0; start_o=0; CONTROL=0; A, B, FLAGS and every scratchpad word = 0. Reset mid-transfer aborts it with no completion.

Test Plan:
- Write CONTROL=0x0000_0301 (N-1=3, start) with busy_i=0 → pready_o in the 2nd ACCESS cycle, pslverr_o=0, start_o=1 for exactly one cycle, ctrl_o=0x0300. Read CONTROL → 0x0300.
- Write A row0 (W=1, paddr=0x0008)=0x0000_0002_0000_0001, then read it back → same value; a_o[63:0] matches.
- Hold busy_i=1; write B row0 (paddr=0x0028) → pslverr_o=1, b_o unchanged. Read FLAGS → pslverr_o=0.
- CONTROL.write_target=2, pulse res_valid_i with element e = e+100 and flags_i=0x0010 → scratchpad slot 2 element 5 reads 105; FLAGS=0x0010. A second pulse with flags_i=0x0001 → FLAGS=0x0011. Write FLAGS → reads 0.
- Misaligned paddr=0x0004 and out-of-map paddr=0xFFF8 → pslverr_o=1, prdata_o=0, no state change.
- Assert rst_ni=0 during the ACCESS wait state → pready_o=0 immediately and all registers read 0 after release.

Source files
------------

// File: rtl/matmul_apb_slave.sv
// APB3 register front-end for the matmul core: control, operand rows, sticky flags, result scratchpad.
// Latency: setup + one wait-state cycle (read data registered) + one response cycle with pready_o; start_o one cycle after commit.
// Backpressure: none towards the core (res_valid_i is always accepted); APB always inserts exactly one wait state.
module matmul_apb_slave #(
  parameter int BUS_WIDTH   = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   psel_i,
  input  logic                                   penable_i,
  input  logic                                   pwrite_i,
  input  logic [ADDR_WIDTH-1:0]                  paddr_i,
  input  logic [BUS_WIDTH-1:0]                   pwdata_i,
  output logic [BUS_WIDTH-1:0]                   prdata_o,
  output logic                                   pready_o,
  output logic                                   pslverr_o,
  input  logic                                   busy_i,
  input  logic                                   res_valid_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   res_data_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]             flags_i,
  output logic                                   start_o,
  output logic [15:0]                            ctrl_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]           a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0]           b_o,
  output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   c_o
);

  localparam int N       = MAX_DIM;
  localparam int NN      = N * N;
  localparam int SP_WORDS = SP_NTARGETS * NN;
  localparam int W_B0    = N + 1;
  localparam int W_FLAGS = 2 * N + 1;
  localparam int W_SP0   = 2 * N + 2;
  localparam int W_END   = W_SP0 + SP_WORDS;
  // Stored CONTROL bits: mode_bias, targets, and the three dimension fields.
  localparam logic [15:0] CTRL_MASK = 16'h3F3E;
  localparam logic [1:0]  SLOT_MASK = 2'(SP_NTARGETS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic                  to_access;
  logic [15:0]           ctrl_q;
  logic [BUS_WIDTH-1:0]  a_q [N];
  logic [BUS_WIDTH-1:0]  b_q [N];
  logic [NN-1:0]         flags_q;
  logic [BUS_WIDTH-1:0]  sp_q [SP_WORDS];
  logic [BUS_WIDTH-1:0]  prdata_q;
  logic                  pready_q, pslverr_q, start_q;

  logic [31:0]           w_idx;
  logic                  misalign, hit_ctrl, hit_a, hit_b, hit_flags, hit_sp;
  logic                  mapped, guarded, acc_err, wr_commit, flags_clr;
  logic [BUS_WIDTH-1:0]  rdata;
  logic [1:0]            cap_slot, rd_slot;
  logic                  unused_pwdata;

  assign unused_pwdata = ^pwdata_i[BUS_WIDTH-1:16];

  // Address decode on the word index
  assign w_idx     = 32'(paddr_i[ADDR_WIDTH-1:3]);
  assign misalign  = |paddr_i[2:0];
  assign hit_ctrl  = (w_idx == 32'd0);
  assign hit_a     = (w_idx >= 32'd1) && (w_idx <= 32'(N));
  assign hit_b     = (w_idx >= 32'(W_B0)) && (w_idx <= 32'(2 * N));
  assign hit_flags = (w_idx == 32'(W_FLAGS));
  assign hit_sp    = (w_idx >= 32'(W_SP0)) && (w_idx < 32'(W_END));
  assign mapped    = hit_ctrl | hit_a | hit_b | hit_flags | hit_sp;
  // Everything except FLAGS is frozen for APB writes while the core computes.
  assign guarded   = hit_ctrl | hit_a | hit_b | hit_sp;
  assign acc_err   = misalign | ~mapped | (pwrite_i & busy_i & guarded);

  // Busy is re-checked at commit so a core that starts mid-transfer is never disturbed.
  assign wr_commit = (state_q == ACCESS) & psel_i & penable_i & pwrite_i & ~pslverr_q
                     & ~(busy_i & guarded);
  assign flags_clr = wr_commit & hit_flags;

  assign cap_slot  = ctrl_q[3:2] & SLOT_MASK;
  assign rd_slot   = ctrl_q[5:4] & SLOT_MASK;

  // Read mux over all storage, sampled in the wait-state cycle
  always_comb begin
    rdata = '0;
    if (hit_ctrl)  rdata = BUS_WIDTH'(ctrl_q);
    if (hit_flags) rdata = BUS_WIDTH'(flags_q);
    for (int i = 0; i < N; i++) begin
      if (w_idx == 32'(1 + i))    rdata = a_q[i];
      if (w_idx == 32'(W_B0 + i)) rdata = b_q[i];
    end
    for (int j = 0; j < SP_WORDS; j++) begin
      if (w_idx == 32'(W_SP0 + j)) rdata = sp_q[j];
    end
  end

  // APB FSM next-state: SETUP doubles as the wait-state cycle once penable_i rises
  always_comb begin
    state_d   = state_q;
    to_access = 1'b0;
    case (state_q)
      IDLE:    if (psel_i && !penable_i) state_d = SETUP;
      SETUP: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          state_d   = ACCESS;
          to_access = 1'b1;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Registered APB response, valid only in the cycle after the wait state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= to_access;
      pslverr_q <= to_access & acc_err;
      prdata_q  <= (to_access && !acc_err && !pwrite_i) ? rdata : '0;
    end
  end

  // CONTROL register and start pulse; the start bit itself is never stored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= wr_commit & hit_ctrl & pwdata_i[0];
      if (wr_commit && hit_ctrl) ctrl_q <= pwdata_i[15:0] & CTRL_MASK;
    end
  end

  // Operand A/B rows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (wr_commit) begin
      for (int i = 0; i < N; i++) begin
        if (w_idx == 32'(1 + i))    a_q[i] <= pwdata_i;
        if (w_idx == 32'(W_B0 + i)) b_q[i] <= pwdata_i;
      end
    end
  end

  // Sticky overflow flags; a coinciding capture overrides the APB clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (res_valid_i) begin
      flags_q <= (flags_clr ? '0 : flags_q) | flags_i;
    end else if (flags_clr) begin
      flags_q <= '0;
    end
  end

  // Scratchpad: APB word writes, then whole-slot capture (later assignment wins on collision)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < SP_WORDS; j++) sp_q[j] <= '0;
    end else begin
      for (int j = 0; j < SP_WORDS; j++) begin
        if (wr_commit && w_idx == 32'(W_SP0 + j)) sp_q[j] <= pwdata_i;
      end
      for (int s = 0; s < SP_NTARGETS; s++) begin
        for (int e = 0; e < NN; e++) begin
          if (res_valid_i && cap_slot == 2'(s))
            sp_q[s * NN + e] <= res_data_i[e * BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  // Flatten storage towards the core
  always_comb begin
    a_o = '0;
    b_o = '0;
    c_o = '0;
    for (int i = 0; i < N; i++) begin
      a_o[i * BUS_WIDTH +: BUS_WIDTH] = a_q[i];
      b_o[i * BUS_WIDTH +: BUS_WIDTH] = b_q[i];
    end
    for (int s = 0; s < SP_NTARGETS; s++) begin
      for (int e = 0; e < NN; e++) begin
        if (rd_slot == 2'(s)) c_o[e * BUS_WIDTH +: BUS_WIDTH] = sp_q[s * NN + e];
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign start_o   = start_q;
  assign ctrl_o    = ctrl_q;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave with a 4x4 configuration.
// Latency: drives full APB transfers and expects pready_o on the second cycle after setup.
// Backpressure: bounded waits on pready_o; an expired bound counts as a failure.
module tb_matmul_apb_slave;

  localparam int BW  = 64;
  localparam int N   = 4;
  localparam int NN  = N * N;
  localparam int SP  = 4;
  localparam int CW  = NN * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [15:0]   paddr;
  logic [BW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic          busy, res_valid;
  logic [CW-1:0] res_data;
  logic [NN-1:0] flags;
  logic          start;
  logic [15:0]   ctrl;
  logic [N*BW-1:0] a_o, b_o;
  logic [CW-1:0] c_o;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  // reference model state
  logic [15:0]   m_ctrl;
  logic [BW-1:0] m_a [N];
  logic [BW-1:0] m_b [N];
  logic [NN-1:0] m_flags;
  logic [BW-1:0] m_sp [SP*NN];
  int            m_starts;

  matmul_apb_slave #(
    .BUS_WIDTH(64), .DATA_WIDTH(16), .ADDR_WIDTH(16), .SP_NTARGETS(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .busy_i(busy), .res_valid_i(res_valid), .res_data_i(res_data),
    .flags_i(flags), .start_o(start), .ctrl_o(ctrl), .a_o(a_o), .b_o(b_o), .c_o(c_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void m_reset();
    m_ctrl = '0; m_flags = '0; m_starts = 0;
    for (int i = 0; i < N; i++) begin m_a[i] = '0; m_b[i] = '0; end
    for (int j = 0; j < SP*NN; j++) m_sp[j] = '0;
  endfunction

  function automatic void m_capture(input logic [CW-1:0] cd, input logic [NN-1:0] cf);
    int slot = int'(m_ctrl[3:2]) % SP;
    for (int e = 0; e < NN; e++) m_sp[slot*NN + e] = cd[e*BW +: BW];
    m_flags = m_flags | cf;
  endfunction

  // One APB transfer against the model. phase: 0 none, 1 capture during wait state, 2 capture at commit.
  function automatic void m_xfer(input bit wr, input logic [15:0] addr, input logic [BW-1:0] wd,
                                 input bit bsy, input int phase, input logic [CW-1:0] cd,
                                 input logic [NN-1:0] cf, output logic [BW-1:0] erd, output logic eerr);
    int w = int'(addr >> 3);
    bit mapped = (w <= 2*N + 1 + SP*NN);
    bit is_flags = (w == 2*N + 1);
    eerr = (addr[2:0] != 3'd0) || !mapped || (wr && bsy && !is_flags);
    erd = '0;
    if (!eerr && !wr) begin
      if (w == 0)            erd = BW'(m_ctrl);
      else if (w <= N)       erd = m_a[w-1];
      else if (w <= 2*N)     erd = m_b[w-N-1];
      else if (is_flags)     erd = BW'(m_flags);
      else                   erd = m_sp[w-2*N-2];
    end
    if (phase == 1) m_capture(cd, cf);
    if (wr && !eerr) begin
      if (w == 0) begin
        m_ctrl = wd[15:0] & 16'h3F3E;
        if (wd[0]) m_starts++;
      end
      else if (w <= N)       m_a[w-1] = wd;
      else if (w <= 2*N)     m_b[w-N-1] = wd;
      else if (is_flags)     m_flags = '0;
      else                   m_sp[w-2*N-2] = wd;
    end
    if (phase == 2) m_capture(cd, cf);
  endfunction

  function automatic logic [N*BW-1:0] exp_a();
    logic [N*BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = m_a[i];
    return r;
  endfunction

  function automatic logic [N*BW-1:0] exp_b();
    logic [N*BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = m_b[i];
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_c();
    logic [CW-1:0] r;
    int slot = int'(m_ctrl[5:4]) % SP;
    for (int e = 0; e < NN; e++) r[e*BW +: BW] = m_sp[slot*NN + e];
    return r;
  endfunction

  // ---------------- APB driver (called just after a rising edge) ----------------
  task automatic apb(input bit wr, input logic [15:0] addr, input logic [BW-1:0] wd,
                     input int phase, input logic [CW-1:0] cd, input logic [NN-1:0] cf,
                     output logic [BW-1:0] rd, output logic err, output int lat);
    bit got;
    rd = '0; err = 1'bx; lat = -1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got = (pready === 1'b1);
      if (got) begin rd = prdata; err = pslverr; lat = c; end
      if ((phase == 1 && c == 1) || (phase == 2 && got)) begin
        res_valid = 1'b1; res_data = cd; flags = cf;
      end
      @(posedge clk); #1;
      res_valid = 1'b0;
      if (got) break;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_result(input logic [CW-1:0] cd, input logic [NN-1:0] cf);
    res_valid = 1'b1; res_data = cd; flags = cf;
    @(posedge clk); #1;
    res_valid = 1'b0;
    m_capture(cd, cf);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat;
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL rst_pready: got %b want 0", pready); end
    total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
    total++; if (prdata !== '0) begin bad++; $display("FAIL rst_prdata: got %h want 0", prdata); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", start); end
    total++; if (ctrl !== 16'h0) begin bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
    total++; if (a_o !== '0 || b_o !== '0) begin bad++; $display("FAIL rst_ab: got a=%h b=%h want 0", a_o, b_o); end
    total++; if (c_o !== '0) begin bad++; $display("FAIL rst_c: got nonzero c_o, want 0"); end
    m_xfer(0, 16'h0000, '0, busy, 0, '0, '0, erd, eerr);
    apb(0, 16'h0000, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0 || err !== 1'b0) begin bad++; $display("FAIL rst_read_ctrl: got %h err=%b want 0 err=0", rd, err); end
  endtask

  task automatic test_control();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat;
    busy = 1'b0;
    m_xfer(1, 16'h0000, 64'h0000_0301, 0, 0, '0, '0, erd, eerr);
    apb(1, 16'h0000, 64'h0000_0301, 0, '0, '0, rd, err, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL ctrl_latency: got %0d cycles want 2", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ctrl_err: got %b want 0", err); end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL start_high: got %b want 1", start); end
    @(posedge clk); #1;
    total++; if (start !== 1'b0) begin bad++; $display("FAIL start_width: got %b want 0", start); end
    total++; if (ctrl !== 16'h0300) begin bad++; $display("FAIL ctrl_o: got %h want 0300", ctrl); end
    m_xfer(0, 16'h0000, '0, 0, 0, '0, '0, erd, eerr);
    apb(0, 16'h0000, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0300 || err !== 1'b0) begin bad++; $display("FAIL ctrl_read: got %h err=%b want 0300 err=0", rd, err); end
  endtask

  task automatic test_a_row();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat;
    logic [BW-1:0] v = 64'h0000_0002_0000_0001;
    m_xfer(1, 16'h0008, v, 0, 0, '0, '0, erd, eerr);
    apb(1, 16'h0008, v, 0, '0, '0, rd, err, lat);
    m_xfer(0, 16'h0008, '0, 0, 0, '0, '0, erd, eerr);
    apb(0, 16'h0008, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== v || err !== 1'b0) begin bad++; $display("FAIL a_row_read: got %h err=%b want %h", rd, err, v); end
    total++; if (a_o[63:0] !== v) begin bad++; $display("FAIL a_o_row0: got %h want %h", a_o[63:0], v); end
  endtask

  task automatic test_busy();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat, s0;
    logic [BW-1:0] x = 64'h1111_2222_3333_4444;
    busy = 1'b0;
    m_xfer(1, 16'h0028, x, 0, 0, '0, '0, erd, eerr);
    apb(1, 16'h0028, x, 0, '0, '0, rd, err, lat);
    busy = 1'b1;
    m_xfer(1, 16'h0028, 64'hDEAD, 1, 0, '0, '0, erd, eerr);
    apb(1, 16'h0028, 64'hDEAD, 0, '0, '0, rd, err, lat);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL busy_b_err: got %b want 1", err); end
    total++; if (b_o[63:0] !== x) begin bad++; $display("FAIL busy_b_kept: got %h want %h", b_o[63:0], x); end
    s0 = start_cnt;
    m_xfer(1, 16'h0000, 64'h0000_00F1, 1, 0, '0, '0, erd, eerr);
    apb(1, 16'h0000, 64'h0000_00F1, 0, '0, '0, rd, err, lat);
    @(posedge clk); #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL busy_ctrl_err: got %b want 1", err); end
    total++; if (start_cnt !== s0 || ctrl !== m_ctrl) begin bad++; $display("FAIL busy_no_start: starts %0d->%0d ctrl=%h want ctrl=%h", s0, start_cnt, ctrl, m_ctrl); end
    m_xfer(0, 16'h0048, '0, 1, 0, '0, '0, erd, eerr);
    apb(0, 16'h0048, '0, 0, '0, '0, rd, err, lat);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL busy_flags_read: got err=%b want 0", err); end
    busy = 1'b0;
  endtask

  task automatic test_capture();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat;
    logic [CW-1:0] cd;
    logic [15:0] a25 = 16'((2*N + 2 + 2*NN + 5) * 8);
    m_xfer(1, 16'h0000, 64'h0328, 0, 0, '0, '0, erd, eerr);
    apb(1, 16'h0000, 64'h0328, 0, '0, '0, rd, err, lat);
    for (int e = 0; e < NN; e++) cd[e*BW +: BW] = 64'(e + 100);
    pulse_result(cd, 16'h0010);
    apb(0, a25, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'd105 || err !== 1'b0) begin bad++; $display("FAIL cap_slot2_e5: got %0d err=%b want 105", rd, err); end
    total++; if (c_o[5*BW +: BW] !== 64'd105) begin bad++; $display("FAIL cap_c_o_e5: got %0d want 105", c_o[5*BW +: BW]); end
    apb(0, 16'h0048, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0010) begin bad++; $display("FAIL flags_first: got %h want 0010", rd); end
    pulse_result(cd, 16'h0001);
    apb(0, 16'h0048, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0011) begin bad++; $display("FAIL flags_sticky: got %h want 0011", rd); end
    m_xfer(1, 16'h0048, 64'h5, 0, 0, '0, '0, erd, eerr);
    apb(1, 16'h0048, 64'h5, 0, '0, '0, rd, err, lat);
    apb(0, 16'h0048, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0) begin bad++; $display("FAIL flags_clear: got %h want 0", rd); end
    // clear racing a capture: the new flags survive
    m_xfer(1, 16'h0048, '0, 0, 2, cd, 16'h0104, erd, eerr);
    apb(1, 16'h0048, '0, 2, cd, 16'h0104, rd, err, lat);
    apb(0, 16'h0048, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'h0104) begin bad++; $display("FAIL flags_race: got %h want 0104", rd); end
    // scratchpad write colliding with capture: core data wins
    for (int e = 0; e < NN; e++) cd[e*BW +: BW] = 64'(e + 200);
    m_xfer(1, a25, 64'hABCD, 0, 2, cd, '0, erd, eerr);
    apb(1, a25, 64'hABCD, 2, cd, '0, rd, err, lat);
    apb(0, a25, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'd205) begin bad++; $display("FAIL sp_collision: got %0d want 205", rd); end
    // read while a capture lands in the wait state returns the old word
    for (int e = 0; e < NN; e++) cd[e*BW +: BW] = 64'(e + 300);
    m_xfer(0, a25, '0, 0, 1, cd, '0, erd, eerr);
    apb(0, a25, '0, 1, cd, '0, rd, err, lat);
    total++; if (rd !== 64'd205) begin bad++; $display("FAIL read_during_cap: got %0d want 205", rd); end
    apb(0, a25, '0, 0, '0, '0, rd, err, lat);
    total++; if (rd !== 64'd305) begin bad++; $display("FAIL read_after_cap: got %0d want 305", rd); end
  endtask

  task automatic test_errors();
    logic [BW-1:0] rd, erd; logic err, eerr; int lat;
    logic [15:0] addrs [4] = '{16'h0004, 16'hFFF8, 16'((2*N + 2 + SP*NN) * 8), 16'h000B};
    for (int k = 0; k < 4; k++) begin
      m_xfer(0, addrs[k], '0, 0, 0, '0, '0, erd, eerr);
      apb(0, addrs[k], '0, 0, '0, '0, rd, err, lat);
      total++; if (err !== 1'b1 || rd !== '0) begin bad++; $display("FAIL err_read[%0h]: got err=%b rd=%h want err=1 rd=0", addrs[k], err, rd); end
      m_xfer(1, addrs[k], 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, '0, '0, erd, eerr);
      apb(1, addrs[k], 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, '0, rd, err, lat);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_write[%0h]: got err=%b want 1", addrs[k], err); end
    end
    total++; if (ctrl !== m_ctrl || a_o !== exp_a()) begin bad++; $display("FAIL err_no_change: ctrl=%h want %h", ctrl, m_ctrl); end
    m_xfer(0, 16'((2*N + 1 + SP*NN) * 8), '0, 0, 0, '0, '0, erd, eerr);
    apb(0, 16'((2*N + 1 + SP*NN) * 8), '0, 0, '0, '0, rd, err, lat);
    total++; if (err !== 1'b0 || rd !== erd) begin bad++; $display("FAIL last_sp_word: got err=%b rd=%h want err=0 rd=%h", err, rd, erd); end
  endtask

  task automatic test_random();
    logic [BW-1:0] rd, erd, wd; logic err, eerr; int lat, w, phase; bit wr;
    logic [15:0] addr; logic [CW-1:0] cd; logic [NN-1:0] cf;
    for (int it = 0; it < 250; it++) begin
      w = $urandom_range(0, 2*N + 3 + SP*NN);
      addr = 16'(w * 8);
      if ($urandom_range(0, 15) == 0) addr[2:0] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 24) == 0) addr = 16'hFFF8;
      wr = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      busy = ($urandom_range(0, 3) == 0);
      phase = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int e = 0; e < NN; e++) cd[e*BW +: BW] = {$urandom, $urandom};
      cf = NN'($urandom);
      m_xfer(wr, addr, wd, busy, phase, cd, cf, erd, eerr);
      apb(wr, addr, wd, phase, cd, cf, rd, err, lat);
      total++; if (lat !== 2 || err !== eerr) begin bad++; $display("FAIL rand_resp[%0d] addr=%h wr=%b: lat=%0d err=%b want lat=2 err=%b", it, addr, wr, lat, err, eerr); end
      if (!wr) begin
        total++; if (rd !== erd) begin bad++; $display("FAIL rand_read[%0d] addr=%h: got %h want %h", it, addr, rd, erd); end
      end
    end
    busy = 1'b0;
    @(posedge clk); #1;
    total++; if (ctrl !== m_ctrl) begin bad++; $display("FAIL rand_ctrl_o: got %h want %h", ctrl, m_ctrl); end
    total++; if (a_o !== exp_a() || b_o !== exp_b()) begin bad++; $display("FAIL rand_ab: a=%h b=%h want a=%h b=%h", a_o, b_o, exp_a(), exp_b()); end
    total++; if (c_o !== exp_c()) begin bad++; $display("FAIL rand_c_o: got %h want %h", c_o, exp_c()); end
    total++; if (start_cnt !== m_starts) begin bad++; $display("FAIL rand_starts: got %0d want %0d", start_cnt, m_starts); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] rd; logic err; int lat;
    logic [15:0] raddrs [4] = '{16'h0000, 16'h0008, 16'h0048, 16'((2*N + 2) * 8)};
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0008;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (pready !== 1'b0 || prdata !== '0) begin bad++; $display("FAIL rst_mid_now: pready=%b prdata=%h want 0", pready, prdata); end
    @(negedge clk);
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL rst_mid_held: pready=%b want 0", pready); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    m_reset();
    start_cnt = 0;
    @(posedge clk); #1;
    total++; if (ctrl !== 16'h0 || a_o !== '0 || b_o !== '0 || c_o !== '0) begin bad++; $display("FAIL rst_mid_outputs: ctrl=%h a=%h b=%h want 0", ctrl, a_o, b_o); end
    for (int k = 0; k < 4; k++) begin
      apb(0, raddrs[k], '0, 0, '0, '0, rd, err, lat);
      total++; if (rd !== '0 || err !== 1'b0 || lat !== 2) begin bad++; $display("FAIL rst_mid_read[%0h]: got %h err=%b lat=%0d want 0", raddrs[k], rd, err, lat); end
    end
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    busy = 1'b0; res_valid = 1'b0; res_data = '0; flags = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_control();
    test_a_row();
    test_busy();
    test_capture();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
